// File: rtl/ram_cmd_port.sv
// ram_cmd_port
// Command-driven single-port RAM behind an SPI slave. Each rx_valid-qualified
// 10-bit command word carries a 2-bit opcode and an 8-bit payload:
//   00 WR_ADDR : latch write address, arm writes
//   01 WR_DATA : write payload to mem[wr_addr] (needs armed write address)
//   10 RD_ADDR : latch read address, arm reads
//   11 RD_DATA : load dout from mem[rd_addr] (needs armed read address)
// A data command with no armed address does nothing except pulse err for
// exactly the following cycle.
//
// Ports:
//   clk      in   1   system clock, all state updates on rising edge
//   rst      in   1   asynchronous active-high reset (memory not cleared)
//   din      in  10   command word {opcode[1:0], payload[7:0]}
//   rx_valid in   1   din qualifier
//   dout     out  8   read data to the SPI slave
//   tx_valid out  1   dout qualifier, high while the tx FSM is in TX_HOLD
//   err      out  1   one-cycle pulse after a data command with no address
//
// Optional feature macro: RAM_AUTO_INC_EN
//   When defined, wr_addr / rd_addr post-increment (wrapping at MEM_DEPTH)
//   after every successful WR_DATA / RD_DATA.
//
// tx FSM:
//   state   | meaning
//   TX_IDLE | no read data offered, tx_valid = 0, dout keeps last value
//   TX_HOLD | read data offered, tx_valid = 1, dout held stable

module ram_cmd_port #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_armed;
    logic                 r_rd_armed;
    logic [7:0]           r_dout;
    logic                 r_err;
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_next;

    logic [1:0]           w_opcode;
    logic [7:0]           w_payload;
    logic [ADDR_SIZE-1:0] w_cmd_addr;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_cmd_err;

    assign w_opcode   = din[9:8];
    assign w_payload  = din[7:0];
    assign w_cmd_addr = ADDR_SIZE'(din[7:0]);

    assign w_wr_ok   = rx_valid && (w_opcode == OP_WR_DATA) &&  r_wr_armed;
    assign w_rd_ok   = rx_valid && (w_opcode == OP_RD_DATA) &&  r_rd_armed;
    assign w_cmd_err = rx_valid && (((w_opcode == OP_WR_DATA) && !r_wr_armed) ||
                                    ((w_opcode == OP_RD_DATA) && !r_rd_armed));

    // Memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_dout     <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_cmd_err;
            if (rx_valid && (w_opcode == OP_WR_ADDR)) begin
                r_wr_addr  <= w_cmd_addr;
                r_wr_armed <= 1'b1;
            end
            if (rx_valid && (w_opcode == OP_RD_ADDR)) begin
                r_rd_addr  <= w_cmd_addr;
                r_rd_armed <= 1'b1;
            end
            if (w_rd_ok) begin
                r_dout <= r_mem[r_rd_addr];
            end
`ifdef RAM_AUTO_INC_EN
            // Address width equals log2(MEM_DEPTH), so natural overflow wraps.
            if (w_wr_ok) begin
                r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
            end
            if (w_rd_ok) begin
                r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    // An errored data command changes nothing visible besides err, so it
    // does not drop tx_valid either.
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_rd_ok) begin
                    w_tx_next = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (rx_valid && !w_rd_ok && !w_cmd_err) begin
                    w_tx_next = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    assign dout     = r_dout;
    assign tx_valid = (r_tx_state == TX_HOLD);
    assign err      = r_err;

endmodule

// File: tb/tb_ram_cmd_port.sv
module tb_ram_cmd_port;

    logic       clk;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;

    int n_tests;
    int n_fail;

    ram_cmd_port #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one command for exactly one rising edge; returns at the
    // falling edge after that edge, where the command's results are visible.
    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 10'h000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        din      = 10'h000;
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        idle(2);
        rst = 1'b0;

        // Seed mem[0] for the post-reset integrity check
        send(2'b00, 8'h00);
        send(2'b01, 8'h44);

        // Basic write then read-back
        send(2'b00, 8'h3A);
        send(2'b01, 8'h5C);
        send(2'b10, 8'h3A);
        chk("wr_no_tx", 32'(tx_valid), 32'h0);
        send(2'b11, 8'h00);
        chk("rd_dout", 32'(dout), 32'h5C);
        chk("rd_tx_valid", 32'(tx_valid), 32'h1);
        idle(3);
        chk("hold_tx_valid", 32'(tx_valid), 32'h1);
        chk("hold_dout", 32'(dout), 32'h5C);

        // Non-read command in TX_HOLD drops tx_valid, dout retained
        send(2'b00, 8'h10);
        chk("drop_tx_valid", 32'(tx_valid), 32'h0);
        chk("drop_dout", 32'(dout), 32'h5C);
        idle(2);
        chk("idle_dout", 32'(dout), 32'h5C);

        // Write 0x77 at 0x10; din noise while rx_valid low must be ignored
        send(2'b01, 8'h77);
        @(negedge clk);
        din = {2'b01, 8'hEE};
        @(negedge clk);
        din = {2'b00, 8'h99};
        @(negedge clk);
        din = 10'h000;
        chk("noise_no_err", 32'(err), 32'h0);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        chk("rd_0x10", 32'(dout), 32'h77);
        send(2'b10, 8'h3A);
        send(2'b11, 8'h00);
        chk("rd_0x3A_again", 32'(dout), 32'h5C);
        chk("rd_0x3A_tx", 32'(tx_valid), 32'h1);

        // Async reset between edges while in TX_HOLD
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'h0);
        chk("arst_dout", 32'(dout), 32'h00);
        chk("arst_err", 32'(err), 32'h0);
        #1 rst = 1'b0;

        // Data commands before any address command raise err
        send(2'b01, 8'hAA);
        chk("noarm_wr_err", 32'(err), 32'h1);
        idle(1);
        chk("noarm_wr_err_end", 32'(err), 32'h0);
        send(2'b11, 8'h00);
        chk("noarm_rd_err", 32'(err), 32'h1);
        chk("noarm_rd_tx", 32'(tx_valid), 32'h0);
        chk("noarm_rd_dout", 32'(dout), 32'h00);
        idle(1);
        chk("noarm_rd_err_end", 32'(err), 32'h0);
        chk("noarm_rd_tx_end", 32'(tx_valid), 32'h0);

        // Memory intact after reset and failed write
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        chk("mem0_intact", 32'(dout), 32'h44);
        chk("mem0_no_err", 32'(err), 32'h0);
        send(2'b10, 8'h3A);
        send(2'b11, 8'h00);
        chk("mem3A_intact", 32'(dout), 32'h5C);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        chk("mem10_intact", 32'(dout), 32'h77);

        // Address reuse / auto-increment wrap at 0xFF
        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'hFF);
        send(2'b11, 8'h00);
`ifdef RAM_AUTO_INC_EN
        chk("wrap_rd1", 32'(dout), 32'h11);
`else
        chk("wrap_rd1", 32'(dout), 32'h22);
`endif
        send(2'b11, 8'h00);
        chk("wrap_rd2", 32'(dout), 32'h22);
        chk("wrap_rd2_tx", 32'(tx_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
